// File: rtl/letreiro_controlador.sv
// Sequencing controller for the six-digit rotating marquee.
// Debounces the raw switches and produces load, shift and direction strobes for the ring datapath.

module letreiro_debounce #(
    parameter int DEB_CYC = 500_000
) (
    input  logic clk50MHZ,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;

    // The synchronized value must differ from db for DEB_CYC consecutive cycles before db follows it.
    always_ff @(posedge clk50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != db) begin
                if (cnt == DW'(DEB_CYC - 1)) begin
                    db  <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// state | meaning
// RST   | first cycle after reset release
// CARGA | datapath takes the initial pattern (load=1), offset cleared
// GIRA  | rotating, one shift every DIV cycles
// PAUSA | paused, single steps via the step button
module letreiro_controlador #(
    parameter int DIV     = 20_000_000,
    parameter int DEB_CYC = 500_000,
    parameter int N_DISP  = 6
) (
    input  logic       clk50MHZ,
    input  logic       rst_n,
    input  logic       stop,
    input  logic       dir_sw,
    input  logic       step,
    output logic       load,
    output logic       shift_en,
    output logic       shift_dir,
    output logic [2:0] offset,
    output logic       running
);
    typedef enum logic [1:0] {
        RST   = 2'd0,
        CARGA = 2'd1,
        GIRA  = 2'd2,
        PAUSA = 2'd3
    } state_t;

    localparam int         CW   = $clog2(DIV);
    localparam logic [2:0] LAST = 3'(N_DISP - 1);

    state_t        state;
    state_t        state_nxt;
    logic          stop_db;
    logic          dir_db;
    logic          step_db;
    logic          step_prev;
    logic          step_pulse;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          shift_c;

    letreiro_debounce #(.DEB_CYC(DEB_CYC)) u_deb_stop (
        .clk50MHZ (clk50MHZ),
        .rst_n    (rst_n),
        .raw      (stop),
        .db       (stop_db)
    );

    letreiro_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dir (
        .clk50MHZ (clk50MHZ),
        .rst_n    (rst_n),
        .raw      (dir_sw),
        .db       (dir_db)
    );

    letreiro_debounce #(.DEB_CYC(DEB_CYC)) u_deb_step (
        .clk50MHZ (clk50MHZ),
        .rst_n    (rst_n),
        .raw      (step),
        .db       (step_db)
    );

    always_ff @(posedge clk50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_db;
        end
    end

    assign step_pulse = step_db & ~step_prev;

    // Counter only runs in GIRA, so every entry into GIRA starts a full DIV period.
    always_ff @(posedge clk50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == GIRA) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign tick = (state == GIRA) && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_c   = 1'b0;
        case (state)
            RST:   state_nxt = CARGA;
            CARGA: state_nxt = stop_db ? PAUSA : GIRA;
            GIRA: begin
                if (stop_db) begin
                    state_nxt = PAUSA;
                end else if (tick) begin
                    shift_c = 1'b1;
                end
            end
            PAUSA: begin
                // A step arriving with the stop release is served first; rotation resumes a cycle later.
                if (step_pulse) begin
                    shift_c = 1'b1;
                end else if (!stop_db) begin
                    state_nxt = GIRA;
                end
            end
            default: state_nxt = RST;
        endcase
    end

    always_ff @(posedge clk50MHZ or negedge rst_n) begin
        if (!rst_n) begin
            offset <= 3'd0;
        end else if (state == CARGA) begin
            offset <= 3'd0;
        end else if (shift_c) begin
            if (dir_db) begin
                offset <= (offset == 3'd0) ? LAST : offset - 3'd1;
            end else begin
                offset <= (offset == LAST) ? 3'd0 : offset + 3'd1;
            end
        end
    end

    // All strobes decode registered state, so shift_dir and the offset step always agree.
    assign load      = (state == CARGA);
    assign running   = (state == GIRA);
    assign shift_en  = shift_c;
    assign shift_dir = dir_db;
endmodule
